// File: rtl/fb_pkg.sv
// Shared parameters, types and helpers for the framebuffer port arbiter.
package fb_pkg;

  localparam int ADDR_W        = 11;
  localparam int DATA_W        = 8;
  localparam int COORD_W       = 7;
  localparam int BYTES_PER_ROW = 16;
  localparam int DISP_LATENCY  = 2;
  localparam int IDX_W         = 3;   // bit index of a pixel inside one byte

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [IDX_W-1:0]  idx_t;

  // One-byte display cache entry.
  typedef struct packed {
    logic  valid;
    addr_t tag;
    data_t data;
  } cache_t;

  // Pixel 0 of a byte is its MSB (leftmost on screen), so index i selects bit 7-i.
  function automatic logic pick_pixel(input data_t b, input idx_t idx);
    idx_t bit_sel;
    bit_sel = ~idx;
    return b[bit_sel];
  endfunction

endpackage

// File: rtl/fb_addr_map.sv
// Maps a 128x128 1bpp display coordinate to a framebuffer byte address and bit index.
module fb_addr_map
  import fb_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic [IDX_W-1:0]   idx
);

  // Row-major layout: 16 bytes per row, 8 pixels per byte.
  always_comb begin
    addr = ADDR_W'(y) * ADDR_W'(BYTES_PER_ROW) + ADDR_W'(x[COORD_W-1:IDX_W]);
    idx  = x[IDX_W-1:0];
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Arbitrates a single-port framebuffer RAM between a display pixel stream
// (absolute priority, one-byte cache, fixed 2-cycle latency) and a host port.
module fb_port_arbiter
  import fb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               disp_req,
  input  logic [COORD_W-1:0] disp_x,
  input  logic [COORD_W-1:0] disp_y,
  input  logic               disp_sof,
  output logic               disp_pixel,
  output logic               disp_valid,
  input  logic               host_valid,
  input  logic               host_we,
  input  logic [ADDR_W-1:0]  host_addr,
  input  logic [DATA_W-1:0]  host_wdata,
  output logic               host_ready,
  output logic [DATA_W-1:0]  host_rdata,
  output logic               host_rvalid,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_we,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata
);

  addr_t disp_addr;
  idx_t  disp_idx;

  fb_addr_map u_addr_map (
    .x    (disp_x),
    .y    (disp_y),
    .addr (disp_addr),
    .idx  (disp_idx)
  );

  cache_t cache_q, cache_eff, cache_d;

  // Display pipeline: vld_q[0] is stage 2, vld_q[DISP_LATENCY-1] is the output.
  logic [DISP_LATENCY-1:0] vld_q;
  logic  s1_hit_q;
  idx_t  s1_idx_q;
  addr_t s1_addr_q;
  data_t s1_byte_q;

  addr_t addr_hold_q;
  data_t wdata_hold_q;
  logic  rd_pend_q;

  logic  fill, hit, disp_miss, host_xfer, host_wr, host_rd;
  data_t s2_byte;

  assign disp_valid = vld_q[DISP_LATENCY-1];

  // Cache lookup (with the in-flight fill forwarded), arbitration and RAM port drive.
  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    fill      = vld_q[0] && !s1_hit_q;
    cache_eff = cache_q;
    if (fill) cache_eff = '{valid: 1'b1, tag: s1_addr_q, data: ram_rdata};

    // A start-of-frame forces the coincident request to re-read the RAM.
    hit        = cache_eff.valid && (cache_eff.tag == disp_addr) && !disp_sof;
    disp_miss  = rst_n && disp_req && !hit;
    host_ready = !disp_miss;
    host_xfer  = rst_n && host_valid && host_ready;
    host_wr    = host_xfer && host_we;
    host_rd    = host_xfer && !host_we;

    // Host writes keep the cache coherent and win over a same-cycle fill.
    cache_d = cache_eff;
    if (host_wr && cache_eff.valid && (host_addr == cache_eff.tag)) cache_d.data = host_wdata;
    if (disp_sof) cache_d.valid = 1'b0;

    s2_byte = s1_hit_q ? s1_byte_q : ram_rdata;

    ram_we    = host_wr;
    ram_wdata = host_wr ? host_wdata : wdata_hold_q;
    ram_addr  = addr_hold_q;
    if (disp_miss)      ram_addr = disp_addr;
    else if (host_xfer) ram_addr = host_addr;
    if (!rst_n)         ram_addr = '0;
  end

  // Pipeline, cache, host read return and RAM address/data hold registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_q      <= '0;
      vld_q        <= '0;
      s1_hit_q     <= 1'b0;
      s1_idx_q     <= '0;
      s1_addr_q    <= '0;
      s1_byte_q    <= '0;
      disp_pixel   <= 1'b0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      rd_pend_q    <= 1'b0;
      host_rvalid  <= 1'b0;
      host_rdata   <= '0;
    end else begin
      cache_q <= cache_d;
      vld_q   <= {vld_q[DISP_LATENCY-2:0], disp_req};
      if (disp_req) begin
        s1_hit_q  <= hit;
        s1_idx_q  <= disp_idx;
        s1_addr_q <= disp_addr;
        s1_byte_q <= cache_eff.data;   // pre-write byte if the host writes this cycle
      end
      if (vld_q[0]) disp_pixel <= pick_pixel(s2_byte, s1_idx_q);
      addr_hold_q  <= ram_addr;
      wdata_hold_q <= ram_wdata;
      rd_pend_q    <= host_rd;
      host_rvalid  <= rd_pend_q;
      if (rd_pend_q) host_rdata <= ram_rdata;
    end
  end

endmodule
